mem_port_arbiter: RTL

Arbiter and sequencer that shares one single-port unified memory between the pipeline's instruction-fetch port and data (load/store) port. It sits between the core and the memory, replacing the separate instruction and data paths. It grants one transaction at a time, waits out a fixed memory read latency, and returns fetch words unchanged. Load data is returned byte/halfword-extracted and sign- or zero-extended per RISC-V funct3 size.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 23 ++
 rtl/mem_port_arbiter_load_extend.sv | 24 ++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic {IDLE, WAIT} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_H, SZ_HU: bad = off[0];
      SZ_W:        bad = (off != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side (fetch/data) and memory-side signals of the arbiter in one bundle.
interface mem_port_arbiter_if;
  logic        if_req, if_ready, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ready, d_rvalid, d_misalign;
  logic [2:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we;
  logic [2:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;

  // slave: the arbiter itself; master: requesters plus memory model
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata,
    output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata, d_misalign,
           m_req, m_we, m_size, m_addr, m_wdata
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata,
    input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata, d_misalign,
           m_req, m_we, m_size, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_load_extend.sv
// Byte/halfword extraction and sign/zero extension of a loaded word.
module load_extend
  import mem_arb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    result = {{24{b[7]}}, b};
      SZ_BU:   result = {24'h0, b};
      SZ_H:    result = {{16{h[15]}}, h};
      SZ_HU:   result = {16'h0, h};
      default: result = word;
    endcase
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data ports; data wins by default.
// Define MEM_ARB_FAIRNESS_EN to force a fetch grant after STREAK_MAX contested data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LAT        = 1,
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  if (LAT < 1 || LAT > 4) begin : g_bad_lat
    $error("mem_port_arbiter: LAT must be 1..4");
  end
  if (STREAK_MAX < 1 || STREAK_MAX > 255) begin : g_bad_streak
    $error("mem_port_arbiter: STREAK_MAX must be 1..255");
  end

  arb_state_t  state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  owner_t      owner;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] if_hold, d_hold, ext;
  logic        resp, accept, force_if, grant_d, grant_if, mis, d_go, rd_start;

  // A response cycle doubles as an acceptance cycle, so reads pipeline at one per LAT.
  assign resp     = (state == WAIT) && (cnt == 2'd0);
  assign accept   = reset && ((state == IDLE) || resp);
  assign grant_d  = bus.d_req && !force_if;
  assign grant_if = bus.if_req && !grant_d;
  assign mis      = misaligned(bus.d_size, bus.d_addr[1:0]);

  assign bus.if_ready   = accept && grant_if;
  assign bus.d_ready    = accept && grant_d;
  assign bus.d_misalign = bus.d_ready && mis;
  assign d_go           = bus.d_ready && !mis;
  assign rd_start       = bus.if_ready || (d_go && !bus.d_we);

  assign bus.m_req   = bus.if_ready || d_go;
  assign bus.m_we    = d_go && bus.d_we;
  assign bus.m_size  = bus.m_we ? bus.d_size : (bus.m_req ? SZ_W : 3'b000);
  assign bus.m_addr  = bus.if_ready ? {bus.if_addr[31:2], 2'b00} : (d_go ? bus.d_addr : 32'h0);
  assign bus.m_wdata = bus.m_we ? bus.d_wdata : 32'h0;

  assign bus.if_rvalid = resp && (owner == OWN_IF);
  assign bus.d_rvalid  = resp && (owner == OWN_D);

  load_extend u_ext (
    .word   (bus.m_rdata),
    .off    (off_q),
    .size   (size_q),
    .result (ext)
  );

  assign bus.if_rdata = bus.if_rvalid ? bus.m_rdata : if_hold;
  assign bus.d_rdata  = bus.d_rvalid ? ext : d_hold;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == WAIT && cnt != 2'd0) begin
      cnt_nx = cnt - 2'd1;
    end else if (rd_start) begin
      state_nx = WAIT;
      cnt_nx   = 2'(LAT - 1);
    end else begin
      state_nx = IDLE;
      cnt_nx   = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      owner   <= OWN_IF;
      size_q  <= SZ_W;
      off_q   <= 2'd0;
      if_hold <= 32'h0;
      d_hold  <= 32'h0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (rd_start) begin
        owner  <= bus.if_ready ? OWN_IF : OWN_D;
        size_q <= bus.d_size;
        off_q  <= bus.d_addr[1:0];
      end
      if (bus.if_rvalid) if_hold <= bus.m_rdata;
      if (bus.d_rvalid)  d_hold  <= ext;
    end
  end

`ifdef MEM_ARB_FAIRNESS_EN
  logic [7:0] streak;

  assign force_if = bus.if_req && (streak == 8'(STREAK_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                                    streak <= 8'd0;
    else if (bus.if_ready)                                         streak <= 8'd0;
    else if (bus.d_ready && bus.if_req && streak != 8'(STREAK_MAX)) streak <= streak + 8'd1;
  end
`else
  assign force_if = 1'b0;
`endif

endmodule
